memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, maximum RAM wait cycles before a request is aborted.
REQ-002 Port: CLK  input  1  system clock, all state on rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous, active-high.
REQ-004 Port: imemRen  input  1  instruction fetch request from request unit.
REQ-005 Port: imemaddr  input  32  instruction fetch address.
REQ-006 Port: dmmRen  input  1  data load request.
REQ-007 Port: dmmWen  input  1  data store request.
REQ-008 Port: dmmaddr  input  32  data address.
REQ-009 Port: dmmstore  input  32  store data.
REQ-010 Port: i_ready  output  1  one-cycle pulse, instruction access complete.
REQ-011 Port: d_ready  output  1  one-cycle pulse, data access complete.
REQ-012 Port: imemload  output  32  fetched instruction, valid while i_ready=1.
REQ-013 Port: dmmload  output  32  loaded data, valid while d_ready=1.
REQ-014 Port: ram_ren / ram_wen  output  1 each  single RAM port strobes, registered.
REQ-015 Port: ram_addr / ram_wdata  output  32 each  RAM address / write data, registered.
REQ-016 Port: ram_rdata  input  32  RAM read data, valid in the cycle ram_busy=0.
REQ-017 Port: ram_busy  input  1  RAM wait; access completes in first strobed cycle with ram_busy=0.
REQ-018 Port: arb_err  output  1  one-cycle pulse with i_ready/d_ready when the access timed out.

Function
REQ-019 FSM states SHALL be IDLE, IREQ, DREQ, RESP.
REQ-020 IDLE: dmmRen|dmmWen -> DREQ, latching dmmaddr, dmmstore, write flag; else imemRen -> IREQ, latching imemaddr; else stay.
REQ-021 Data requests SHALL have strict priority over instruction requests when both are pending in IDLE.
REQ-022 dmmRen and dmmWen both high SHALL be treated as a store.
REQ-023 IREQ/DREQ: ram_ren (or ram_wen for stores) held 1, ram_addr/ram_wdata held at latched values every cycle.
REQ-024 IREQ/DREQ with ram_busy=0: capture ram_rdata into imemload/dmmload (stores capture nothing), go RESP.
REQ-025 Wait counter clears on entering IREQ/DREQ, increments each busy cycle; at TIMEOUT_CYCLES busy cycles go RESP with arb_err set, load output forced to 0.
REQ-026 RESP: exactly one of i_ready/d_ready high for one cycle, RAM strobes low, then unconditionally IDLE.
REQ-027 RESP SHALL NOT sample requests, so a still-high Ren/Wen at the ready edge never causes a duplicate access.
REQ-028 Latency: request in IDLE cycle N, zero-wait RAM -> strobe in N+1, ready in N+2; each busy cycle adds one.
REQ-029 Request inputs changing during IREQ/DREQ SHALL be ignored until the next IDLE.
REQ-030 imemload/dmmload SHALL hold last captured value outside their ready pulses.
REQ-031 RAM strobes SHALL be 0 in IDLE and RESP; never both ram_ren and ram_wen high.

Reset
REQ-032 RST high SHALL asynchronously force IDLE, counter 0, all outputs 0, including mid-access; the aborted access produces no ready pulse.
REQ-033 First request SHALL be accepted in the first IDLE cycle after RST falls.

Structure
REQ-034 State enum arb_state_t and default TIMEOUT value SHALL live in the shared cpu_pkg alongside cuOPType.
REQ-035 The wait counter SHALL be one sub-module, arb_timeout_ctr (clear, enable, expired output).

Verification
REQ-036 imemRen=1, imemaddr=32'h12341234, ram_busy=0, ram_rdata=32'h00500093 -> ram_ren+addr next cycle, i_ready=1, imemload=32'h00500093 one cycle later, single strobe only.
REQ-037 dmmWen=1, dmmaddr=32'h00010001, dmmstore=32'hABCDABCD, ram_busy=1 for 3 cycles -> ram_wen held 4 cycles with those values, then d_ready pulse, arb_err=0.
REQ-038 imemRen=1 and dmmRen=1 together, ram_rdata=32'hCAFEF00D -> data served first (d_ready, dmmload=32'hCAFEF00D), fetch issued after RESP->IDLE.
REQ-039 ram_busy stuck 1, TIMEOUT_CYCLES=4 -> after 4 busy cycles d_ready=1, arb_err=1, dmmload=0, then IDLE.
REQ-040 RST asserted during DREQ wait -> strobes drop immediately, no d_ready; after release a new imemRen completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package.
// Contents:
//   cuOPType            - control-unit operation type used by the datapath
//   arb_state_t         - memory arbiter FSM state encoding
//   ARB_TIMEOUT_DEFAULT - default RAM wait limit for the memory arbiter
//   arb_ctr_width()     - counter width able to hold values 0..limit-1
`timescale 1ns/1ps
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_LUI  = 4'd10,
        OP_NOP  = 4'd15
    } cuOPType;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IREQ = 2'd1,
        ARB_DREQ = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_t;

    localparam int ARB_TIMEOUT_DEFAULT = 255;

    // Width of a counter that must reach limit-1; never narrower than 1 bit.
    function automatic int arb_ctr_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// RAM wait counter for the memory arbiter.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - zero the count (held while the arbiter is idle)
//   enable    - one RAM busy cycle observed this cycle
//   expired   - combinational: this busy cycle is the LIMIT-th one
`timescale 1ns/1ps
module arb_timeout_ctr
    import cpu_pkg::*;
#(
    parameter int LIMIT = ARB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = arb_ctr_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // count_q holds the number of busy cycles already seen, so the current
    // busy cycle is the LIMIT-th one when count_q has reached LIMIT-1.
    assign expired = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Memory arbiter: serialises instruction fetches and data loads/stores onto
// a single RAM port. Data requests win over fetches when both are pending.
// Ports:
//   CLK, RST                  - clock, asynchronous active-high reset
//   imemRen, imemaddr         - instruction fetch request
//   dmmRen, dmmWen, dmmaddr,
//   dmmstore                  - data load/store request (Ren&Wen = store)
//   i_ready / d_ready         - one-cycle completion pulses
//   imemload / dmmload        - captured read data, held between accesses
//   arb_err                   - pulses with the ready when the access timed out
//   ram_ren, ram_wen,
//   ram_addr, ram_wdata       - registered RAM strobes / address / data
//   ram_rdata, ram_busy       - RAM read data and wait indication
//   dbg_state                 - current FSM state
// Handshake: a request is taken only in IDLE; strobes are held through the
// wait, the access completes in the first strobed cycle with ram_busy=0 (or
// after TIMEOUT_CYCLES busy cycles), and one RESP cycle carries the ready
// pulse before returning to IDLE. Requests are never sampled outside IDLE.
`timescale 1ns/1ps
module memory_arbiter
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemRen,
    input  logic [31:0] imemaddr,
    input  logic        dmmRen,
    input  logic        dmmWen,
    input  logic [31:0] dmmaddr,
    input  logic [31:0] dmmstore,
    output logic        i_ready,
    output logic        d_ready,
    output logic [31:0] imemload,
    output logic [31:0] dmmload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_busy,
    output logic        arb_err,
    output arb_state_t  dbg_state
);

    arb_state_t  state_q, state_d;
    logic        wr_q, wr_d;
    logic        ram_ren_q, ram_ren_d;
    logic        ram_wen_q, ram_wen_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        arb_err_q, arb_err_d;
    logic [31:0] imemload_q, imemload_d;
    logic [31:0] dmmload_q, dmmload_d;

    logic in_access;
    logic ctr_clear;
    logic ctr_enable;
    logic timed_out;

    assign in_access  = (state_q == ARB_IREQ) || (state_q == ARB_DREQ);
    // Counter is zero whenever an access starts because it is cleared in IDLE.
    assign ctr_clear  = (state_q == ARB_IDLE);
    assign ctr_enable = in_access && ram_busy;

    arb_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLK),
        .rst    (RST),
        .clear  (ctr_clear),
        .enable (ctr_enable),
        .expired(timed_out)
    );

    // All outputs are registered, so they are computed from the next state:
    // strobes are asserted when entering/remaining in IREQ/DREQ, readies when
    // entering RESP.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        ram_ren_d   = 1'b0;
        ram_wen_d   = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        arb_err_d   = 1'b0;
        imemload_d  = imemload_q;
        dmmload_d   = dmmload_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (dmmRen || dmmWen) begin
                    state_d     = ARB_DREQ;
                    wr_d        = dmmWen;
                    ram_ren_d   = !dmmWen;
                    ram_wen_d   = dmmWen;
                    ram_addr_d  = dmmaddr;
                    ram_wdata_d = dmmWen ? dmmstore : 32'h0;
                end else if (imemRen) begin
                    state_d     = ARB_IREQ;
                    wr_d        = 1'b0;
                    ram_ren_d   = 1'b1;
                    ram_addr_d  = imemaddr;
                    ram_wdata_d = 32'h0;
                end
            end

            ARB_IREQ: begin
                if (!ram_busy) begin
                    state_d    = ARB_RESP;
                    i_ready_d  = 1'b1;
                    imemload_d = ram_rdata;
                end else if (timed_out) begin
                    state_d    = ARB_RESP;
                    i_ready_d  = 1'b1;
                    arb_err_d  = 1'b1;
                    imemload_d = 32'h0;
                end else begin
                    ram_ren_d  = 1'b1;
                end
            end

            ARB_DREQ: begin
                if (!ram_busy) begin
                    state_d   = ARB_RESP;
                    d_ready_d = 1'b1;
                    if (!wr_q) begin
                        dmmload_d = ram_rdata;
                    end
                end else if (timed_out) begin
                    state_d   = ARB_RESP;
                    d_ready_d = 1'b1;
                    arb_err_d = 1'b1;
                    dmmload_d = 32'h0;
                end else begin
                    ram_ren_d = !wr_q;
                    ram_wen_d = wr_q;
                end
            end

            ARB_RESP: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ARB_IDLE;
            wr_q        <= 1'b0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= 32'h0;
            ram_wdata_q <= 32'h0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            arb_err_q   <= 1'b0;
            imemload_q  <= 32'h0;
            dmmload_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            arb_err_q   <= arb_err_d;
            imemload_q  <= imemload_d;
            dmmload_q   <= dmmload_d;
        end
    end

    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign imemload  = imemload_q;
    assign dmmload   = dmmload_q;
    assign ram_ren   = ram_ren_q;
    assign ram_wen   = ram_wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign arb_err   = arb_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed accesses push their
// expected RAM-side and response-side items into queues; a monitor pops and
// compares them whenever the DUT strobes the RAM or pulses a ready.
`timescale 1ns/1ps
module tb_memory_arbiter;
    import cpu_pkg::*;

    localparam int TO = 4;
    localparam int W  = 42;   // {is_data, err, strobes[7:0], data[31:0]}
    localparam int RW = 65;   // {wen, addr[31:0], wdata[31:0]}

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemRen, dmmRen, dmmWen;
    logic [31:0] imemaddr, dmmaddr, dmmstore;
    logic        i_ready, d_ready, arb_err;
    logic [31:0] imemload, dmmload;
    logic        ram_ren, ram_wen;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_busy;
    arb_state_t  dbg_state;

    memory_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .imemRen(imemRen), .imemaddr(imemaddr),
        .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
        .i_ready(i_ready), .d_ready(d_ready),
        .imemload(imemload), .dmmload(dmmload),
        .ram_ren(ram_ren), .ram_wen(ram_wen),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_busy(ram_busy),
        .arb_err(arb_err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0]  exp_q[$];
    logic [RW-1:0] ram_q[$];
    logic [31:0]   last_imem = 32'h0;
    logic [31:0]   last_dmm  = 32'h0;
    int            strobe_cnt = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] item;
        forever begin
            @(posedge CLK);
            #1;
            if (RST) begin
                strobe_cnt = 0;
            end else begin
                if (ram_ren || ram_wen) begin
                    check("strobe_exclusive", 80'(ram_ren && ram_wen), 80'(0));
                    if (ram_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_strobe actual ren=%b wen=%b addr=%h required none",
                                 ram_ren, ram_wen, ram_addr);
                    end else begin
                        check("ram_side", 80'({ram_wen, ram_addr, ram_wdata}), 80'(ram_q[0]));
                    end
                    strobe_cnt++;
                end
                if (i_ready || d_ready) begin
                    check("ready_exclusive", 80'(i_ready && d_ready), 80'(0));
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ready actual i=%b d=%b required none", i_ready, d_ready);
                    end else begin
                        item = exp_q.pop_front();
                        check("response",
                              80'({d_ready, arb_err, 8'(strobe_cnt), (d_ready ? dmmload : imemload)}),
                              80'(item));
                        if (ram_q.size() > 0) void'(ram_q.pop_front());
                    end
                    strobe_cnt = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_reqs();
        imemRen = 1'b0;
        dmmRen  = 1'b0;
        dmmWen  = 1'b0;
    endtask

    // Called in the middle of an IDLE cycle; returns in the middle of the
    // next IDLE cycle after the access has completed.
    task automatic run_access(input bit is_d, input bit rd, input bit wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int busy,
                              input bit to, input bit hold, input bit wiggle);
        bit          is_w;
        logic [31:0] data_exp;
        int          c;
        is_w = is_d && wr;
        if (to)        data_exp = 32'h0;
        else if (is_w) data_exp = last_dmm;
        else           data_exp = rdata;
        if (is_d) last_dmm = data_exp;
        else      last_imem = data_exp;
        c = to ? TO : busy + 1;
        exp_q.push_back({is_d, to, 8'(c), data_exp});
        ram_q.push_back({is_w, addr, (is_w ? wdata : 32'h0)});

        if (is_d) begin
            dmmRen  = rd;
            dmmWen  = wr;
            dmmaddr = addr;
        end else begin
            imemRen  = 1'b1;
            imemaddr = addr;
        end
        dmmstore  = wdata;
        ram_busy  = to || (busy > 0);
        ram_rdata = rdata;

        for (int i = 0; i < c; i++) begin
            @(negedge CLK);
            if (i == 0 && !hold) clear_reqs();
            if (wiggle) begin
                imemRen  = 1'($urandom_range(0, 1));
                dmmRen   = 1'($urandom_range(0, 1));
                dmmWen   = 1'($urandom_range(0, 1));
                imemaddr = $urandom;
                dmmaddr  = $urandom;
                dmmstore = $urandom;
            end
            if (!to && i == busy) ram_busy = 1'b0;
        end
        @(negedge CLK);   // RESP
        clear_reqs();
        ram_busy = 1'b0;
        @(negedge CLK);   // IDLE
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_imemload_hold"}, 80'(imemload), 80'(last_imem));
        check({tag, "_dmmload_hold"}, 80'(dmmload), 80'(last_dmm));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1;
        clear_reqs();
        imemaddr  = 32'h0;
        dmmaddr   = 32'h0;
        dmmstore  = 32'h0;
        ram_rdata = 32'h0;
        ram_busy  = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_outputs", 80'({i_ready, d_ready, arb_err, ram_ren, ram_wen}), 80'(0));
        check("rst_buses", 80'({imemload, dmmload}), 80'(0));
        check("rst_ram_bus", 80'({ram_addr, ram_wdata}), 80'(0));
        check("rst_state", 80'(dbg_state), 80'(ARB_IDLE));

        // First request taken in the first IDLE cycle after reset release.
        @(negedge CLK);
        RST = 1'b0;
        run_access(1'b0, 1'b1, 1'b0, 32'h12341234, 32'h5555AAAA, 32'h00500093, 0, 1'b0, 1'b0, 1'b0);
        check_hold("after_fetch");

        // Store with three wait cycles.
        run_access(1'b1, 1'b0, 1'b1, 32'h00010001, 32'hABCDABCD, 32'h77777777, 3, 1'b0, 1'b0, 1'b0);
        check_hold("after_store");

        // Load with one wait; request held through RESP must not repeat.
        run_access(1'b1, 1'b1, 1'b0, 32'h00000100, 32'h11110000, 32'hDEADBEEF, 1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("no_duplicate_strobe", 80'({ram_ren, ram_wen}), 80'(0));
        end
        @(negedge CLK);

        // Ren and Wen together are a store.
        run_access(1'b1, 1'b1, 1'b1, 32'h00002000, 32'h0BADF00D, 32'h99999999, 0, 1'b0, 1'b0, 1'b0);
        check_hold("after_ren_wen");

        // Fetch with request inputs toggling during the wait.
        run_access(1'b0, 1'b1, 1'b0, 32'h00400000, 32'h0, 32'h13579BDF, 2, 1'b0, 1'b0, 1'b1);
        check_hold("after_wiggle");

        // Data beats instruction; fetch follows after RESP->IDLE.
        exp_q.push_back({1'b1, 1'b0, 8'd1, 32'hCAFEF00D});
        ram_q.push_back({1'b0, 32'h00003000, 32'h0});
        exp_q.push_back({1'b0, 1'b0, 8'd1, 32'h11112222});
        ram_q.push_back({1'b0, 32'h00000040, 32'h0});
        last_dmm  = 32'hCAFEF00D;
        last_imem = 32'h11112222;
        imemRen   = 1'b1;
        imemaddr  = 32'h00000040;
        dmmRen    = 1'b1;
        dmmaddr   = 32'h00003000;
        ram_busy  = 1'b0;
        ram_rdata = 32'hCAFEF00D;
        @(negedge CLK);            // DREQ
        dmmRen = 1'b0;
        @(negedge CLK);            // RESP
        ram_rdata = 32'h11112222;
        @(negedge CLK);            // IDLE, fetch still pending
        @(negedge CLK);            // IREQ
        imemRen = 1'b0;
        @(negedge CLK);            // RESP
        @(negedge CLK);            // IDLE
        check_hold("after_priority");

        // Timeouts: load then fetch, RAM stuck busy.
        run_access(1'b1, 1'b1, 1'b0, 32'h00004000, 32'h0, 32'h44444444, 0, 1'b1, 1'b0, 1'b0);
        run_access(1'b0, 1'b1, 1'b0, 32'h00000080, 32'h0, 32'h55555555, 0, 1'b1, 1'b0, 1'b0);
        check_hold("after_timeouts");

        // Reset in the middle of a data wait.
        ram_q.push_back({1'b0, 32'h00005000, 32'h0});
        dmmRen   = 1'b1;
        dmmaddr  = 32'h00005000;
        ram_busy = 1'b1;
        @(negedge CLK);            // DREQ 1
        dmmRen = 1'b0;
        @(negedge CLK);            // DREQ 2
        #2;
        RST = 1'b1;
        #1;
        check("rst_mid_strobes", 80'({ram_ren, ram_wen}), 80'(0));
        check("rst_mid_ready", 80'({i_ready, d_ready, arb_err}), 80'(0));
        check("rst_mid_state", 80'(dbg_state), 80'(ARB_IDLE));
        check("rst_mid_loads", 80'({imemload, dmmload}), 80'(0));
        ram_q.delete();
        last_imem = 32'h0;
        last_dmm  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("rst_hold_no_ready", 80'({d_ready, ram_ren, ram_wen}), 80'(0));
        end
        @(negedge CLK);
        RST      = 1'b0;
        ram_busy = 1'b0;
        run_access(1'b0, 1'b1, 1'b0, 32'h00000200, 32'h0, 32'h00A00113, 0, 1'b0, 1'b0, 1'b0);
        check_hold("after_reset_fetch");

        repeat (3) @(negedge CLK);
        check("exp_q_drained", 80'(exp_q.size()), 80'(0));
        check("ram_q_drained", 80'(ram_q.size()), 80'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
